ascon_out_framer: RTL
=====================

ASCON_OUT_FRAMER -- requirements
Module: ascon_out_framer

Interface
REQ-001 SHALL have parameter NUM_SHARES, default 2: number of Boolean shares on bdo.
REQ-002 SHALL have parameter CCW, default 32: word width; values other than 32 SHALL fail elaboration.
REQ-003 SHALL have parameter DEPTH, default 8: maximum words per segment buffer (2..16).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 bdo  in  NUM_SHARES*CCW  masked output words from the core; share i occupies [i*CCW +: CCW].
REQ-007 bdo_valid  in  1  bdo word valid.
REQ-008 bdo_ready  out  1  framer accepts the bdo word this cycle.
REQ-009 bdo_type  in  4  segment type (D_PTCT, D_TAG, D_HASH).
REQ-010 bdo_eot  in  1  current word is last of its segment.
REQ-011 auth  in  1  tag verification result.
REQ-012 auth_valid  in  1  auth valid.
REQ-013 auth_ready  out  1  framer accepts auth this cycle.
REQ-014 out_data  out  CCW  framed, unshared output word.
REQ-015 out_valid  out  1  out_data valid.
REQ-016 out_ready  in  1  downstream accepts out_data.
REQ-017 out_hdr  out  1  current out_data is a header word.
REQ-018 err  out  1  sticky type-consistency error.

Function
REQ-019 Unshared word SHALL be XOR of all NUM_SHARES slices of bdo, computed combinationally before buffering.
REQ-020 FSM states SHALL be FILL, HDR, DRAIN, VHDR, VDAT; reset state FILL.
REQ-021 In FILL, bdo_ready SHALL be 1 and auth_ready SHALL be 1 only while the word count is 0; elsewhere both SHALL be 0.
REQ-022 A bdo transfer (bdo_valid & bdo_ready) SHALL write the unshared word at index cnt, increment cnt, and latch bdo_type on the first word (cnt==0).
REQ-023 FILL -> HDR on a transfer with bdo_eot=1 (flags[0]=1) or when cnt reaches DEPTH on that transfer (flags[0]=0, segment continues in a new frame).
REQ-024 Header word SHALL be {type[3:0], flags[3:0], bytes[23:0]}, bytes = cnt*4; flags[3:1]=0.
REQ-025 HDR: out_valid=1, out_hdr=1; on out_ready -> DRAIN with read index 0.
REQ-026 DRAIN: out_valid=1, out_hdr=0, out_data=buffer[rd]; on out_ready rd increments; after word cnt-1 is taken -> FILL with cnt=0.
REQ-027 In FILL with cnt==0, auth_valid & auth_ready SHALL latch auth and go to VHDR; if bdo_valid and auth_valid coincide, auth SHALL win and bdo_ready SHALL be 0 that cycle.
REQ-028 VHDR: header {4'hF, 4'h1, 24'd4}; on out_ready -> VDAT.
REQ-029 VDAT: out_data = {31'b0, auth}; on out_ready -> FILL.
REQ-030 Latency: header SHALL be valid the cycle after the closing transfer; one output word per cycle under continuous out_ready.
REQ-031 out_data/out_hdr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-032 bdo words are not accepted while HDR/DRAIN/VHDR/VDAT (back-pressure, no loss).

Reset
REQ-033 On rst: state FILL, cnt=0, rd=0, out_valid=0, out_hdr=0, out_data=0, err=0; bdo_ready=1 and auth_ready=1 the cycle after rst deasserts.
REQ-034 rst mid-segment or mid-drain SHALL discard all buffered words without emitting them.

Configuration
REQ-035 Macro FRAMER_TYPE_CHECK_EN defined: a transfer with cnt>0 whose bdo_type differs from the latched type SHALL set err=1 (sticky until rst); word still accepted.
REQ-036 Macro undefined: err SHALL be tied 0; no comparison logic.

Verification
REQ-037 NUM_SHARES=2, 4 D_TAG words with shares (X, X^W), eot on 4th, out_ready=1 -> header {D_TAG,4'h1,24'd16} then W0..W3, one per cycle.
REQ-038 10 D_PTCT words, no eot until 10th, DEPTH=8 -> header flags=0 bytes=32 + 8 words, then header flags=1 bytes=8 + 2 words.
REQ-039 auth_valid=1 auth=1 while idle -> {F,1,000004} then 32'h00000001; simultaneous bdo_valid sees bdo_ready=0.
REQ-040 out_ready held 0 for 5 cycles during DRAIN -> out_data unchanged, bdo_ready=0, no word lost after release.
REQ-041 rst pulse after 3 of 4 tag words -> no output; next segment framed correctly from cnt=0.
REQ-042 With FRAMER_TYPE_CHECK_EN: D_PTCT then D_TAG in one segment -> err=1 and stays 1 until rst; without macro err=0.

Source files
------------

// File: rtl/ascon_out_framer.sv
// Output framer for a masked Ascon core: unshares bdo words, buffers one segment
// frame and emits it as header + data words, or a two-word tag-verification frame.
// Optional: define FRAMER_TYPE_CHECK_EN to flag segment-type changes within a frame on err.
module ascon_out_framer #(
    parameter int NUM_SHARES = 2,
    parameter int CCW        = 32,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SHARES*CCW-1:0]  bdo,
    input  logic                       bdo_valid,
    output logic                       bdo_ready,
    input  logic [3:0]                 bdo_type,
    input  logic                       bdo_eot,
    input  logic                       auth,
    input  logic                       auth_valid,
    output logic                       auth_ready,
    output logic [CCW-1:0]             out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_hdr,
    output logic                       err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (CCW != 32) begin : g_bad_ccw
        $error("ascon_out_framer: CCW must be 32");
    end
    if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
        $error("ascon_out_framer: DEPTH must be within 2..16");
    end

    typedef enum logic [2:0] {
        FILL  = 3'd0,
        HDR   = 3'd1,
        DRAIN = 3'd2,
        VHDR  = 3'd3,
        VDAT  = 3'd4
    } state_t;

    function automatic logic [CCW-1:0] unshare(input logic [NUM_SHARES*CCW-1:0] v);
        logic [CCW-1:0] acc;
        acc = {CCW{1'b0}};
        for (int i = 0; i < NUM_SHARES; i++) begin
            acc = acc ^ v[i*CCW +: CCW];
        end
        return acc;
    endfunction

    function automatic logic [31:0] hdr_word(input logic [3:0] t, input logic [3:0] f,
                                             input logic [CNT_W-1:0] n);
        return {t, f, {(22 - CNT_W){1'b0}}, n, 2'b00};
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       rd_q, rd_d;
    logic [3:0]             type_q, type_d;
    logic [3:0]             flags_q, flags_d;
    logic                   auth_q, auth_d;
    logic [CCW-1:0]         out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_hdr_q, out_hdr_d;
    logic [CCW-1:0]         buf_q [DEPTH];
    logic [CCW-1:0]         word_s;
    logic [CNT_W-1:0]       cnt_inc_s;
    logic                   wr_en_s;
    logic                   bdo_ready_s;
    logic                   auth_ready_s;

    assign word_s     = unshare(bdo);
    assign cnt_inc_s  = cnt_q + CNT_W'(1);
    assign bdo_ready  = bdo_ready_s;
    assign auth_ready = auth_ready_s;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_hdr    = out_hdr_q;

    // Next-state, handshake and registered-output next values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        type_d       = type_q;
        flags_d      = flags_q;
        auth_d       = auth_q;
        bdo_ready_s  = 1'b0;
        auth_ready_s = 1'b0;
        wr_en_s      = 1'b0;
        case (state_q)
            FILL: begin
                auth_ready_s = (cnt_q == {CNT_W{1'b0}});
                if (auth_valid && auth_ready_s) begin
                    auth_d  = auth;
                    state_d = VHDR;
                end else begin
                    bdo_ready_s = 1'b1;
                    if (bdo_valid) begin
                        wr_en_s = 1'b1;
                        cnt_d   = cnt_inc_s;
                        if (cnt_q == {CNT_W{1'b0}}) begin
                            type_d = bdo_type;
                        end else begin
                            type_d = type_q;
                        end
                        // a full buffer closes the frame even mid-segment (flags[0]=0)
                        if (bdo_eot || (cnt_inc_s == CNT_W'(DEPTH))) begin
                            flags_d = {3'b000, bdo_eot};
                            state_d = HDR;
                        end else begin
                            state_d = FILL;
                        end
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
            end
            HDR: begin
                if (out_ready) begin
                    rd_d    = {IDX_W{1'b0}};
                    state_d = DRAIN;
                end else begin
                    state_d = HDR;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if ((CNT_W'(rd_q) + CNT_W'(1)) == cnt_q) begin
                        cnt_d   = {CNT_W{1'b0}};
                        rd_d    = {IDX_W{1'b0}};
                        state_d = FILL;
                    end else begin
                        rd_d    = rd_q + IDX_W'(1);
                        state_d = DRAIN;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            VHDR: begin
                if (out_ready) begin
                    state_d = VDAT;
                end else begin
                    state_d = VHDR;
                end
            end
            VDAT: begin
                if (out_ready) begin
                    state_d = FILL;
                end else begin
                    state_d = VDAT;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = {CNT_W{1'b0}};
                rd_d    = {IDX_W{1'b0}};
            end
        endcase

        out_valid_d = 1'b0;
        out_hdr_d   = 1'b0;
        out_data_d  = {CCW{1'b0}};
        case (state_d)
            FILL: begin
                out_valid_d = 1'b0;
            end
            HDR: begin
                out_valid_d = 1'b1;
                out_hdr_d   = 1'b1;
                out_data_d  = hdr_word(type_d, flags_d, cnt_d);
            end
            DRAIN: begin
                out_valid_d = 1'b1;
                out_data_d  = buf_q[rd_d];
            end
            VHDR: begin
                out_valid_d = 1'b1;
                out_hdr_d   = 1'b1;
                out_data_d  = {4'hF, 4'h1, 24'd4};
            end
            VDAT: begin
                out_valid_d = 1'b1;
                out_data_d  = {31'd0, auth_d};
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= {CNT_W{1'b0}};
            rd_q        <= {IDX_W{1'b0}};
            type_q      <= 4'h0;
            flags_q     <= 4'h0;
            auth_q      <= 1'b0;
            out_data_q  <= {CCW{1'b0}};
            out_valid_q <= 1'b0;
            out_hdr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            type_q      <= type_d;
            flags_q     <= flags_d;
            auth_q      <= auth_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_hdr_q   <= out_hdr_d;
        end
    end

    // Segment buffer; contents need no reset because cnt gates every read
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_q[cnt_q[IDX_W-1:0]] <= word_s;
        end
    end

`ifdef FRAMER_TYPE_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (wr_en_s && (cnt_q != {CNT_W{1'b0}}) && (bdo_type != type_q)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Sticky type-consistency flag
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
